// File: rtl/data_mem_port_if.sv
`default_nettype none
// ------------------------------------------------------------------------
// data_mem_port_if: pipeline-side and memory-bus signals of data_mem_port.
// Rev 1.0
// ------------------------------------------------------------------------
interface data_mem_port_if;
  logic        mem_read;
  logic        mem_write;
  logic        mode;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        misalign;

  modport master (
    output mem_read, mem_write, mode, sign_ext, addr, wdata, bus_rdata, bus_ack,
    input  stall, rdata, rdata_valid, bus_req, bus_we, bus_addr, bus_be,
           bus_wdata, misalign
  );

  modport slave (
    input  mem_read, mem_write, mode, sign_ext, addr, wdata, bus_rdata, bus_ack,
    output stall, rdata, rdata_valid, bus_req, bus_we, bus_addr, bus_be,
           bus_wdata, misalign
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_port.sv
`default_nettype none
// ------------------------------------------------------------------------
// data_mem_port: byte/word load-store unit bridging the pipeline to a
// single-beat memory bus. Option: DMEM_MISALIGN_TRAP_EN. Rev 1.0
// ------------------------------------------------------------------------
module data_mem_port (
  input  wire logic       clk,
  input  wire logic       rst_n,
  data_mem_port_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        access;
  logic        trap;
  logic        accept;
  logic        stall;

  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_be_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        is_load_q;
  logic        byte_q;
  logic        sext_q;
  logic [1:0]  lane_q;

  logic [7:0]  lane_byte;
  logic [31:0] load_val;

  assign access = bus.mem_read | bus.mem_write;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign_q;

  assign trap = access & ~bus.mode & (bus.addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= (state_q == ST_IDLE) & trap;
  end

  assign bus.misalign = misalign_q;
`else
  assign trap         = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !trap) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus.bus_ack) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Little-endian lane pick and extension use the attributes captured at accept.
  always_comb begin
    lane_byte = 8'h00;
    case (lane_q)
      2'd0: lane_byte = bus.bus_rdata[7:0];
      2'd1: lane_byte = bus.bus_rdata[15:8];
      2'd2: lane_byte = bus.bus_rdata[23:16];
      2'd3: lane_byte = bus.bus_rdata[31:24];
      default: lane_byte = 8'h00;
    endcase
    if (byte_q) load_val = {{24{sext_q & lane_byte[7]}}, lane_byte};
    else        load_val = bus.bus_rdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_be_q      <= 4'h0;
      bus_wdata_q   <= 32'h0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      is_load_q     <= 1'b0;
      byte_q        <= 1'b0;
      sext_q        <= 1'b0;
      lane_q        <= 2'd0;
    end else begin
      rdata_valid_q <= 1'b0;
      if (accept) begin
        bus_req_q  <= 1'b1;
        bus_we_q   <= bus.mem_write;
        is_load_q  <= ~bus.mem_write;
        bus_addr_q <= {bus.addr[31:2], 2'b00};
        byte_q     <= bus.mode;
        sext_q     <= bus.sign_ext;
        lane_q     <= bus.addr[1:0];
        if (bus.mode) begin
          bus_be_q    <= 4'b0001 << bus.addr[1:0];
          bus_wdata_q <= {4{bus.wdata[7:0]}};
        end else begin
          bus_be_q    <= 4'b1111;
          bus_wdata_q <= bus.wdata;
        end
      end
      if ((state_q == ST_REQ) && bus.bus_ack) begin
        bus_req_q <= 1'b0;
        if (is_load_q) begin
          rdata_q       <= load_val;
          rdata_valid_q <= 1'b1;
        end
      end
    end
  end

  assign bus.stall       = stall;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = rdata_valid_q;
  assign bus.bus_req     = bus_req_q;
  assign bus.bus_we      = bus_we_q;
  assign bus.bus_addr    = bus_addr_q;
  assign bus.bus_be      = bus_be_q;
  assign bus.bus_wdata   = bus_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_port.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_data_mem_port: directed self-checking bench for data_mem_port. Rev 1.0
// ------------------------------------------------------------------------
module tb_data_mem_port;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  data_mem_port_if dif ();

  data_mem_port dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    dif.mem_read  = 1'b0;
    dif.mem_write = 1'b0;
    dif.mode      = 1'b0;
    dif.sign_ext  = 1'b0;
    dif.addr      = 32'h0;
    dif.wdata     = 32'h0;
    dif.bus_rdata = 32'h0;
    dif.bus_ack   = 1'b0;
  endtask

  // One complete access: accept cycle, REQ with 'waits' idle cycles before ack, DONE.
  task automatic access(input logic rd, input logic wr, input logic md, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rbus,
                        input int waits, input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic eload, input logic [31:0] erdata);
    dif.mem_read  = rd;
    dif.mem_write = wr;
    dif.mode      = md;
    dif.sign_ext  = sx;
    dif.addr      = a;
    dif.wdata     = wd;
    #1;
    chk("accept_stall", {31'h0, dif.stall}, 32'd1);
    chk("accept_req", {31'h0, dif.bus_req}, 32'd0);
    step();
    dif.mem_read  = 1'b0;
    dif.mem_write = 1'b0;
    dif.mode      = ~md;
    dif.sign_ext  = ~sx;
    dif.addr      = ~a;
    dif.wdata     = ~wd;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin
        dif.bus_ack   = 1'b1;
        dif.bus_rdata = rbus;
      end else begin
        dif.bus_rdata = ~rbus;
      end
      #1;
      chk("req_bus_req", {31'h0, dif.bus_req}, 32'd1);
      chk("req_stall", {31'h0, dif.stall}, 32'd1);
      chk("req_we", {31'h0, dif.bus_we}, {31'h0, wr});
      chk("req_addr", dif.bus_addr, {a[31:2], 2'b00});
      chk("req_be", {28'h0, dif.bus_be}, {28'h0, ebe});
      chk("req_wdata", dif.bus_wdata, ewd);
      step();
      dif.bus_ack   = 1'b0;
      dif.bus_rdata = ~rbus;
    end
    #1;
    chk("done_stall", {31'h0, dif.stall}, 32'd0);
    chk("done_valid", {31'h0, dif.rdata_valid}, {31'h0, eload});
    chk("done_rdata", dif.rdata, erdata);
    chk("done_bus_req", {31'h0, dif.bus_req}, 32'd0);
    chk("done_misalign", {31'h0, dif.misalign}, 32'd0);
    step();
    #1;
    chk("post_valid", {31'h0, dif.rdata_valid}, 32'd0);
    chk("post_rdata", dif.rdata, erdata);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    chk("rst_stall", {31'h0, dif.stall}, 32'd0);
    chk("rst_bus_req", {31'h0, dif.bus_req}, 32'd0);
    chk("rst_we", {31'h0, dif.bus_we}, 32'd0);
    chk("rst_valid", {31'h0, dif.rdata_valid}, 32'd0);
    chk("rst_misalign", {31'h0, dif.misalign}, 32'd0);
    chk("rst_addr", dif.bus_addr, 32'h0);
    chk("rst_be", {28'h0, dif.bus_be}, 32'h0);
    chk("rst_wdata", dif.bus_wdata, 32'h0);
    chk("rst_rdata", dif.rdata, 32'h0);
    rst_n = 1'b1;
    step();

    // Word load, minimum latency
    access(1, 0, 0, 0, 32'h0000_0100, 32'h1111_1111, 32'hDEAD_BEEF, 0,
           4'b1111, 32'h1111_1111, 1, 32'hDEAD_BEEF);
    // LB / LBU lane 3
    access(1, 0, 1, 1, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0,
           4'b1000, 32'h0, 1, 32'hFFFF_FF80);
    access(1, 0, 1, 0, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0,
           4'b1000, 32'h0, 1, 32'h0000_0080);
    // SB lane 1: rdata keeps last load
    access(0, 1, 1, 0, 32'h0000_0201, 32'h1234_56AB, 32'h0, 0,
           4'b0010, 32'hABAB_ABAB, 0, 32'h0000_0080);
    // Word store with five wait cycles
    access(0, 1, 0, 0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0, 5,
           4'b1111, 32'hCAFE_F00D, 0, 32'h0000_0080);
    // Byte loads on other lanes, one wait cycle
    access(1, 0, 1, 1, 32'h0000_0102, 32'h0, 32'h007F_0000, 1,
           4'b0100, 32'h0, 1, 32'h0000_007F);
    access(1, 0, 1, 0, 32'h0000_0010, 32'h0000_0055, 32'h1234_56F0, 0,
           4'b0001, 32'h5555_5555, 1, 32'h0000_00F0);
    access(1, 0, 1, 1, 32'h0000_1001, 32'h0, 32'h0000_9100, 0,
           4'b0010, 32'h0, 1, 32'hFFFF_FF91);
    // Read and write together behaves as a store
    access(1, 1, 0, 0, 32'h0000_0400, 32'h0BAD_BEEF, 32'h7777_7777, 0,
           4'b1111, 32'h0BAD_BEEF, 0, 32'hFFFF_FF91);

    // Stray ack while idle
    dif.bus_ack   = 1'b1;
    dif.bus_rdata = 32'h1357_2468;
    #1;
    chk("stray_stall", {31'h0, dif.stall}, 32'd0);
    step();
    dif.bus_ack = 1'b0;
    #1;
    chk("stray_valid", {31'h0, dif.rdata_valid}, 32'd0);
    chk("stray_req", {31'h0, dif.bus_req}, 32'd0);
    chk("stray_rdata", dif.rdata, 32'hFFFF_FF91);

    // Word load at misaligned address
`ifdef DMEM_MISALIGN_TRAP_EN
    dif.mem_read = 1'b1;
    dif.mode     = 1'b0;
    dif.addr     = 32'h0000_0102;
    #1;
    chk("trap_stall", {31'h0, dif.stall}, 32'd0);
    step();
    dif.mem_read = 1'b0;
    #1;
    chk("trap_misalign", {31'h0, dif.misalign}, 32'd1);
    chk("trap_req", {31'h0, dif.bus_req}, 32'd0);
    step();
    #1;
    chk("trap_misalign_end", {31'h0, dif.misalign}, 32'd0);
    chk("trap_req_end", {31'h0, dif.bus_req}, 32'd0);
`else
    access(1, 0, 0, 0, 32'h0000_0102, 32'h0, 32'h2468_ACE0, 0,
           4'b1111, 32'h0, 1, 32'h2468_ACE0);
`endif

    // Reset during REQ, then a late ack
    idle_inputs();
    dif.mem_read = 1'b1;
    dif.addr     = 32'h0000_0500;
    step();
    dif.mem_read = 1'b0;
    #1;
    chk("abort_req_before", {31'h0, dif.bus_req}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n       = 1'b1;
    dif.bus_ack = 1'b1;
    dif.bus_rdata = 32'h9999_9999;
    #1;
    chk("abort_req_after", {31'h0, dif.bus_req}, 32'd0);
    chk("abort_stall", {31'h0, dif.stall}, 32'd0);
    step();
    dif.bus_ack = 1'b0;
    #1;
    chk("abort_valid", {31'h0, dif.rdata_valid}, 32'd0);
    chk("abort_rdata", dif.rdata, 32'h0);
    chk("abort_req_late", {31'h0, dif.bus_req}, 32'd0);

    // FSM back in IDLE and fully functional
    access(1, 0, 0, 0, 32'h0000_0600, 32'h0, 32'h1357_9BDF, 2,
           4'b1111, 32'h0, 1, 32'h1357_9BDF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
